uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FifoDepth, default 8, receive buffer entries (power of two, >=2).
REQ-002 SHALL have parameter IdleTimeout, default 80, idle clk cycles before timeout flag (>=2).
REQ-003 SHALL define CntW = $clog2(FifoDepth)+1 for all occupancy widths.
REQ-004 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port arst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_i  input  1  receive enable; bytes ignored when low.
REQ-007 SHALL have port rx_data_i  input  8  received byte from UART receiver.
REQ-008 SHALL have port rx_valid_i  input  1  one-cycle pulse qualifying rx_data_i/rx_parity_err_i.
REQ-009 SHALL have port rx_parity_err_i  input  1  parity error for the byte in the same cycle.
REQ-010 SHALL have port flush_i  input  1  synchronous buffer clear.
REQ-011 SHALL have port clr_status_i  input  1  clears sticky status flags.
REQ-012 SHALL have port watermark_i  input  CntW  occupancy threshold for irq; 0 disables.
REQ-013 SHALL have port pop_ready_i  input  1  consumer accepts head entry.
REQ-014 SHALL have port pop_valid_o  output  1  buffer non-empty.
REQ-015 SHALL have port pop_data_o  output  8  head byte (first-word fall-through).
REQ-016 SHALL have port pop_perr_o  output  1  parity error tag of head byte.
REQ-017 SHALL have port count_o  output  CntW  current occupancy.
REQ-018 SHALL have ports overrun_o, perr_o, timeout_o  output  1 each  status flags.
REQ-019 SHALL have port irq_o  output  1  level interrupt.

Function
REQ-020 Push SHALL occur when rx_valid_i && en_i && !flush_i and (count_o<FifoDepth or pop this cycle); entry = {rx_parity_err_i, rx_data_i}.
REQ-021 Pop SHALL occur when pop_valid_o && pop_ready_i && !flush_i; head advances next cycle.
REQ-022 pop_valid_o SHALL equal (count_o!=0); pop_data_o/pop_perr_o SHALL show head combinationally, value don't-care when empty.
REQ-023 Simultaneous push and pop SHALL leave count_o unchanged, including when full (push accepted, no overrun).
REQ-024 Push attempt when full without pop SHALL drop the byte, leave buffer unchanged, and set overrun_o.
REQ-025 Read/write pointers SHALL wrap modulo FifoDepth; count_o SHALL never exceed FifoDepth nor underflow.
REQ-026 flush_i SHALL set count_o to 0 next cycle, discard any same-cycle push/pop, not set overrun_o, and not alter overrun_o/perr_o.
REQ-027 perr_o SHALL set on an accepted push with rx_parity_err_i=1.
REQ-028 overrun_o and perr_o SHALL be sticky until clr_status_i; same-cycle set and clear: set wins.
REQ-029 Timeout FSM SHALL have states T_EMPTY, T_COUNT, T_EXPIRED with an idle counter.
REQ-030 T_EMPTY: counter 0; goes to T_COUNT when buffer becomes non-empty.
REQ-031 T_COUNT: counter increments each cycle without push/pop; any push/pop resets counter to 0; counter reaching IdleTimeout-1 goes to T_EXPIRED.
REQ-032 T_EXPIRED: timeout_o=1; any push or pop goes to T_COUNT (counter 0), or T_EMPTY if buffer becomes empty.
REQ-033 From any state, buffer empty (incl. flush) SHALL go to T_EMPTY; timeout_o=1 only in T_EXPIRED.
REQ-034 irq_o SHALL equal (watermark_i!=0 && count_o>=watermark_i) || overrun_o || perr_o || timeout_o, combinational from registered state.
REQ-035 en_i low SHALL not affect pops, flush, or timeout FSM.

Reset
REQ-036 On arst_ni low, pointers, count_o, overrun_o, perr_o, timeout_o, irq_o SHALL be 0, FSM in T_EMPTY, immediately and asynchronously.
REQ-037 Reset mid-operation SHALL discard all buffered bytes; first cycle after release behaves as empty idle.

Verification
REQ-038 Push 0x41,0x42,0x43 (perr 0,1,0), pop_ready_i=1 later -> pops in order, pop_perr_o 0,1,0, perr_o=1 after second push.
REQ-039 FifoDepth=8: push 9 bytes, no pop -> count_o=8, overrun_o=1, 9th dropped; clr_status_i -> overrun_o=0.
REQ-040 Full buffer, push and pop same cycle -> count_o stays 8, overrun_o=0, new byte at tail.
REQ-041 IdleTimeout=80: one push, no activity -> timeout_o=1 exactly 80 cycles after push; pop -> timeout_o=0 next cycle.
REQ-042 watermark_i=4: 3 pushes irq_o=0, 4th -> irq_o=1; flush_i -> count_o=0, irq_o=0.
REQ-043 arst_ni pulsed low with 5 bytes buffered and overrun_o=1 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if -- bundles the two byte streams of the UART receive
// controller.
//   rx side  : rx_data_i, rx_valid_i, rx_parity_err_i (from the UART receiver)
//   pop side : pop_ready_i (from the consumer), pop_valid_o, pop_data_o,
//              pop_perr_o (towards the consumer)
// slave  modport : the controller's view of the bundle.
// master modport : the view of whatever drives the receiver and consumer sides.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_parity_err_i;
  logic       pop_ready_i;
  logic       pop_valid_o;
  logic [7:0] pop_data_o;
  logic       pop_perr_o;

  modport slave (
    input  rx_data_i, rx_valid_i, rx_parity_err_i, pop_ready_i,
    output pop_valid_o, pop_data_o, pop_perr_o
  );

  modport master (
    output rx_data_i, rx_valid_i, rx_parity_err_i, pop_ready_i,
    input  pop_valid_o, pop_data_o, pop_perr_o
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- receive buffer for a UART receiver.
// Bytes arriving on the rx side are stored with their parity-error tag in a
// first-word fall-through FIFO. The controller keeps sticky overrun and parity
// status, runs an idle timer that flags a non-empty buffer left untouched, and
// raises a level interrupt.
// Ports:
//   clk_i, arst_ni  clock, asynchronous active-low reset
//   en_i            receive enable (gates pushes only)
//   flush_i         synchronous buffer clear
//   clr_status_i    clears overrun_o / perr_o
//   watermark_i     occupancy threshold for irq_o, 0 disables
//   rx              rx byte stream in, head-of-buffer stream out
//   count_o         occupancy
//   overrun_o, perr_o, timeout_o, irq_o  status / interrupt
module uart_rx_ctrl #(
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned IdleTimeout = 80,
  localparam int unsigned CntW       = $clog2(FifoDepth) + 1
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic                clr_status_i,
  input  logic [CntW-1:0]     watermark_i,
  uart_rx_ctrl_if.slave       rx,
  output logic [CntW-1:0]     count_o,
  output logic                overrun_o,
  output logic                perr_o,
  output logic                timeout_o,
  output logic                irq_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned TmrW = $clog2(IdleTimeout);
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(IdleTimeout - 1);

  typedef enum logic [1:0] {
    T_EMPTY   = 2'd0,
    T_COUNT   = 2'd1,
    T_EXPIRED = 2'd2
  } tstate_e;

  logic [8:0]      mem_q [FifoDepth];
  logic [8:0]      mem_d [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            perr_q, perr_d;
  tstate_e         tstate_q, tstate_d;
  logic [TmrW-1:0] idle_cnt_q, idle_cnt_d;

  logic full_s;
  logic rx_take_s;
  logic push_s;
  logic pop_s;
  logic drop_s;
  logic wm_hit_s;

  assign full_s    = (count_q == FullCnt);
  assign pop_s     = (count_q != '0) && rx.pop_ready_i && !flush_i;
  assign rx_take_s = rx.rx_valid_i && en_i && !flush_i;
  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign push_s    = rx_take_s && (!full_s || pop_s);
  assign drop_s    = rx_take_s && full_s && !pop_s;

  // Buffer storage, pointers and occupancy next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {rx.rx_parity_err_i, rx.rx_data_i};
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky status next-state: a new event in the clearing cycle wins.
  always_comb begin
    overrun_d = overrun_q;
    perr_d    = perr_q;
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_status_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (push_s && rx.rx_parity_err_i) begin
      perr_d = 1'b1;
    end else if (clr_status_i) begin
      perr_d = 1'b0;
    end else begin
      perr_d = perr_q;
    end
  end

  // Idle-timeout FSM next-state; an empty buffer always forces T_EMPTY.
  always_comb begin
    tstate_d   = tstate_q;
    idle_cnt_d = idle_cnt_q;
    if (count_d == '0) begin
      tstate_d   = T_EMPTY;
      idle_cnt_d = '0;
    end else begin
      case (tstate_q)
        T_EMPTY: begin
          tstate_d   = T_COUNT;
          idle_cnt_d = '0;
        end
        T_COUNT: begin
          if (push_s || pop_s) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == TmrLast) begin
            tstate_d   = T_EXPIRED;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + TmrW'(1);
          end
        end
        T_EXPIRED: begin
          if (push_s || pop_s) begin
            tstate_d   = T_COUNT;
            idle_cnt_d = '0;
          end else begin
            tstate_d = T_EXPIRED;
          end
        end
        default: begin
          tstate_d   = T_EMPTY;
          idle_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers; reset empties the buffer and clears all status.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      perr_q     <= 1'b0;
      tstate_q   <= T_EMPTY;
      idle_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      perr_q     <= perr_d;
      tstate_q   <= tstate_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign wm_hit_s       = (watermark_i != '0) && (count_q >= watermark_i);

  assign rx.pop_valid_o = (count_q != '0);
  assign rx.pop_data_o  = mem_q[rd_ptr_q][7:0];
  assign rx.pop_perr_o  = mem_q[rd_ptr_q][8];
  assign count_o        = count_q;
  assign overrun_o      = overrun_q;
  assign perr_o         = perr_q;
  assign timeout_o      = (tstate_q == T_EXPIRED);
  assign irq_o          = wm_hit_s || overrun_q || perr_q || timeout_o;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- directed bench for uart_rx_ctrl. Accepted bytes are
// queued as expected entries when driven; a monitor pops and compares each
// time the DUT hands a byte to the consumer.
module tb_uart_rx_ctrl;
  localparam int unsigned Depth = 8;
  localparam int unsigned Idle  = 80;
  localparam int unsigned CntW  = $clog2(Depth) + 1;

  logic            clk_i;
  logic            arst_ni;
  logic            en_i;
  logic            flush_i;
  logic            clr_status_i;
  logic [CntW-1:0] watermark_i;
  logic [CntW-1:0] count_o;
  logic            overrun_o;
  logic            perr_o;
  logic            timeout_o;
  logic            irq_o;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl #(
    .FifoDepth   (Depth),
    .IdleTimeout (Idle)
  ) dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .en_i         (en_i),
    .flush_i      (flush_i),
    .clr_status_i (clr_status_i),
    .watermark_i  (watermark_i),
    .rx           (rx_if.slave),
    .count_o      (count_o),
    .overrun_o    (overrun_o),
    .perr_o       (perr_o),
    .timeout_o    (timeout_o),
    .irq_o        (irq_o)
  );

  int unsigned n_total;
  int unsigned n_pass;
  logic [8:0]  sb_q [$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic p, input bit accept);
    rx_if.rx_data_i       = d;
    rx_if.rx_parity_err_i = p;
    rx_if.rx_valid_i      = 1'b1;
    if (accept) sb_q.push_back({p, d});
    tick();
    rx_if.rx_valid_i      = 1'b0;
    rx_if.rx_parity_err_i = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rx_if.pop_ready_i = 1'b1;
    repeat (n) tick();
    rx_if.pop_ready_i = 1'b0;
  endtask

  // Monitor: compare every byte the consumer takes against the scoreboard.
  initial begin
    logic [8:0] exp_e;
    forever begin
      @(negedge clk_i);
      if (arst_ni && rx_if.pop_valid_o && rx_if.pop_ready_i && !flush_i) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL pop_unexpected: got 0x%0h expected no byte", rx_if.pop_data_o);
        end else begin
          exp_e = sb_q.pop_front();
          check("pop_data", {24'd0, rx_if.pop_data_o}, {24'd0, exp_e[7:0]});
          check("pop_perr", {31'd0, rx_if.pop_perr_o}, {31'd0, exp_e[8]});
        end
      end
    end
  end

  // Watchdog bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_ni               = 1'b0;
    en_i                  = 1'b1;
    flush_i               = 1'b0;
    clr_status_i          = 1'b0;
    watermark_i           = '0;
    rx_if.rx_data_i       = 8'h00;
    rx_if.rx_valid_i      = 1'b0;
    rx_if.rx_parity_err_i = 1'b0;
    rx_if.pop_ready_i     = 1'b0;
    n_total               = 0;
    n_pass                = 0;

    // Reset state
    #2;
    check("rst_count", {28'd0, count_o}, 32'd0);
    check("rst_valid", {31'd0, rx_if.pop_valid_o}, 32'd0);
    check("rst_flags", {29'd0, overrun_o, perr_o, timeout_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    #10 arst_ni = 1'b1;
    tick();

    // Ordered pops with parity tags
    push_byte(8'h41, 1'b0, 1'b1);
    check("perr_after_1", {31'd0, perr_o}, 32'd0);
    push_byte(8'h42, 1'b1, 1'b1);
    check("perr_after_2", {31'd0, perr_o}, 32'd1);
    check("irq_perr", {31'd0, irq_o}, 32'd1);
    push_byte(8'h43, 1'b0, 1'b1);
    check("count_3", {28'd0, count_o}, 32'd3);
    pop_n(3);
    check("count_drained", {28'd0, count_o}, 32'd0);
    clr_status_i = 1'b1;
    tick();
    clr_status_i = 1'b0;
    check("perr_cleared", {31'd0, perr_o}, 32'd0);

    // Disabled receive ignores bytes
    en_i = 1'b0;
    push_byte(8'hEE, 1'b1, 1'b0);
    en_i = 1'b1;
    check("en_low_count", {28'd0, count_o}, 32'd0);
    check("en_low_perr", {31'd0, perr_o}, 32'd0);

    // Overrun: 9 pushes into an 8-deep buffer
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h10 + 8'(i), 1'b0, i < 8);
    end
    check("count_full", {28'd0, count_o}, 32'd8);
    check("overrun_set", {31'd0, overrun_o}, 32'd1);
    check("irq_overrun", {31'd0, irq_o}, 32'd1);
    clr_status_i = 1'b1;
    tick();
    clr_status_i = 1'b0;
    check("overrun_cleared", {31'd0, overrun_o}, 32'd0);
    check("irq_after_clr", {31'd0, irq_o}, 32'd0);

    // Full buffer: push and pop in the same cycle
    rx_if.pop_ready_i = 1'b1;
    push_byte(8'hA5, 1'b0, 1'b1);
    rx_if.pop_ready_i = 1'b0;
    check("full_pp_count", {28'd0, count_o}, 32'd8);
    check("full_pp_overrun", {31'd0, overrun_o}, 32'd0);
    pop_n(8);
    check("count_empty2", {28'd0, count_o}, 32'd0);

    // Idle timeout: exactly Idle cycles after the push edge
    push_byte(8'h77, 1'b0, 1'b1);
    repeat (Idle - 1) tick();
    check("timeout_before", {31'd0, timeout_o}, 32'd0);
    check("irq_before_to", {31'd0, irq_o}, 32'd0);
    tick();
    check("timeout_at", {31'd0, timeout_o}, 32'd1);
    check("irq_timeout", {31'd0, irq_o}, 32'd1);
    pop_n(1);
    check("timeout_after_pop", {31'd0, timeout_o}, 32'd0);

    // Watermark, then flush with a same-cycle byte
    watermark_i = CntW'(4);
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 1'b0, 1'b1);
    check("wm_below", {31'd0, irq_o}, 32'd0);
    push_byte(8'h33, 1'b0, 1'b1);
    check("wm_hit", {31'd0, irq_o}, 32'd1);
    check("wm_count", {28'd0, count_o}, 32'd4);
    flush_i               = 1'b1;
    rx_if.rx_valid_i      = 1'b1;
    rx_if.rx_data_i       = 8'hEE;
    rx_if.rx_parity_err_i = 1'b1;
    sb_q.delete();
    tick();
    flush_i               = 1'b0;
    rx_if.rx_valid_i      = 1'b0;
    rx_if.rx_parity_err_i = 1'b0;
    check("flush_count", {28'd0, count_o}, 32'd0);
    check("flush_irq", {31'd0, irq_o}, 32'd0);
    check("flush_flags", {30'd0, overrun_o, perr_o}, 32'd0);

    // Asynchronous reset with 5 bytes buffered and overrun pending
    watermark_i = '0;
    for (int i = 0; i < 9; i++) push_byte(8'h50 + 8'(i), 1'b0, i < 8);
    pop_n(3);
    check("pre_rst_count", {28'd0, count_o}, 32'd5);
    check("pre_rst_overrun", {31'd0, overrun_o}, 32'd1);
    #2 arst_ni = 1'b0;
    sb_q.delete();
    #1;
    check("arst_count", {28'd0, count_o}, 32'd0);
    check("arst_outs", {28'd0, rx_if.pop_valid_o, overrun_o, perr_o, timeout_o}, 32'd0);
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    tick();
    arst_ni = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, rx_if.pop_valid_o}, 32'd0);
    push_byte(8'h5A, 1'b1, 1'b1);
    check("post_rst_count", {28'd0, count_o}, 32'd1);
    pop_n(1);
    check("post_rst_empty", {28'd0, count_o}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
